// File: rtl/dmem_unit_pkg.sv
// Shared definitions for the byte-serial Y86 data-memory controller.
//   DMEM_DATA_WID : default machine word width in bits (multiple of 8)
//   state_e       : controller states IDLE / ACCESS / DONE
//   cnt_width()   : width of a byte counter able to index every byte of a word
package dmem_unit_pkg;

    localparam int DMEM_DATA_WID = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // A one-byte word still needs a 1-bit counter so the signal exists.
    function automatic int cnt_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide data RAM: synchronous write, asynchronous read, no reset.
//   clk   : write clock
//   we    : write enable, stores wdata at addr on the rising edge
//   addr  : byte address (shared by read and write)
//   wdata : byte to store
//   rdata : combinational read of the byte at addr
module dmem_byte_ram #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_unit.sv
// Byte-serial data-memory controller for the Y86 memory stage.
// Latches one word request, moves it one byte per cycle to/from a byte RAM
// (little-endian) and reports the result as valM with an error flag.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request strobe, only looked at while idle
//   read, write : requested operation (both set is an illegal request)
//   addr, wdata : byte address of the word and data to store
//   rdata       : valM, result of the last completed legal read
//   busy        : high in ACCESS and DONE, stalls the pipeline
//   done        : one-cycle completion pulse
//   dmem_error  : last accepted request was illegal; held until next start
module dmem_unit
    import dmem_unit_pkg::*;
#(
    parameter int DATA_WID  = DMEM_DATA_WID,
    parameter int MEM_BYTES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_WID-1:0] addr,
    input  logic [DATA_WID-1:0] wdata,
    output logic [DATA_WID-1:0] rdata,
    output logic                busy,
    output logic                done,
    output logic                dmem_error
);

    localparam int BYTES = DATA_WID / 8;
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int CW    = cnt_width(BYTES);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DATA_WID-1:0] wdata_q, wdata_d;
    logic                op_read_q, op_read_d;
    logic [DATA_WID-1:0] rbuf_q, rbuf_d;
    logic [DATA_WID-1:0] rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [DATA_WID:0]   end_addr;
    logic                range_err;
    logic                accept;
    logic                illegal;
    logic                last_byte;
    logic [AW-1:0]       ram_addr;
    logic                ram_we;
    logic [7:0]          ram_wdata;
    logic [7:0]          ram_rdata;

    // One extra bit so addresses near the top of the range cannot wrap
    // around and pass the bound check.
    assign end_addr  = {1'b0, addr} + (DATA_WID+1)'(BYTES);
    assign range_err = end_addr > (DATA_WID+1)'(MEM_BYTES);

    assign accept    = (state_q == ST_IDLE) && start && (read || write);
    assign illegal   = (read && write) || range_err;
    assign last_byte = (cnt_q == CW'(BYTES - 1));

    // The range check guarantees addr_q+cnt stays inside the RAM, so only
    // the low AW address bits are kept.
    assign ram_addr  = addr_q + AW'(cnt_q);
    assign ram_we    = (state_q == ST_ACCESS) && !op_read_q;
    assign ram_wdata = wdata_q[8*cnt_q +: 8];

    dmem_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_read_d = op_read_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d    = addr[AW-1:0];
                    wdata_d   = wdata;
                    op_read_d = read;
                    err_d     = 1'b0;
                    if (illegal) begin
                        // Straight to DONE: the RAM and rdata are never touched.
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (op_read_q) begin
                    rbuf_d[8*cnt_q +: 8] = ram_rdata;
                end
                if (last_byte) begin
                    state_d = ST_DONE;
                    // Use rbuf_d so the final byte captured this cycle is included.
                    if (op_read_q) begin
                        rdata_d = rbuf_d;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of the next state.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Request latches and read buffer carry no reset; they are always
    // loaded before being used.
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        op_read_q <= op_read_d;
        rbuf_q    <= rbuf_d;
    end

    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dmem_error = err_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit (32-bit words, 1024-byte RAM).
module tb_dmem_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        dmem_error;

    int passes = 0;
    int total  = 0;

    dmem_unit #(
        .DATA_WID  (32),
        .MEM_BYTES (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .dmem_error (dmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1;
        read  = rd;
        write = wr;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Cycles from accepting edge to the cycle where done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full access, then one extra cycle so the FSM is back in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        issue(rd, wr, a, d);
        wait_done(lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int n_done;
        int n_busy;

        rst_n = 1'b0;
        start = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        addr  = '0;
        wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, dmem_error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back at 0x10
        issue(1'b0, 1'b1, 32'h10, 32'h12345678);
        check("wr_busy", {31'b0, busy}, 32'd1);
        wait_done(lat);
        check("wr_latency", lat, 32'd5);
        check("wr_err", {31'b0, dmem_error}, 32'd0);
        @(posedge clk);
        #1;
        check("wr_busy_after", {31'b0, busy}, 32'd0);
        check("ram10", {24'b0, dut.u_ram.mem[16]}, 32'h78);
        check("ram11", {24'b0, dut.u_ram.mem[17]}, 32'h56);
        check("ram12", {24'b0, dut.u_ram.mem[18]}, 32'h34);
        check("ram13", {24'b0, dut.u_ram.mem[19]}, 32'h12);
        access(1'b1, 1'b0, 32'h10, 32'h0, lat);
        check("rd_latency", lat, 32'd5);
        check("rd_data", rdata, 32'h12345678);
        check("rd_err", {31'b0, dmem_error}, 32'd0);

        // Unaligned read spanning two words
        access(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, lat);
        access(1'b0, 1'b1, 32'h24, 32'h11223344, lat);
        access(1'b1, 1'b0, 32'h22, 32'h0, lat);
        check("unaligned_rd", rdata, 32'h3344AABB);

        // Range error: 1021+4 > 1024
        issue(1'b1, 1'b0, 32'd1021, 32'h0);
        wait_done(lat);
        check("range_latency", lat, 32'd1);
        check("range_err", {31'b0, dmem_error}, 32'd1);
        check("range_busy", {31'b0, busy}, 32'd1);
        check("range_rdata", rdata, 32'h3344AABB);
        @(posedge clk);
        #1;
        check("range_err_held", {31'b0, dmem_error}, 32'd1);
        check("range_idle_busy", {31'b0, busy}, 32'd0);

        // Top-of-range write must not wrap to address 0
        access(1'b0, 1'b1, 32'h0, 32'h5A5A5A5A, lat);
        check("wrap_pre_err", {31'b0, dmem_error}, 32'd0);
        access(1'b0, 1'b1, 32'hFFFFFFFE, 32'h99999999, lat);
        check("wrap_latency", lat, 32'd1);
        check("wrap_err", {31'b0, dmem_error}, 32'd1);
        check("wrap_ram0", {24'b0, dut.u_ram.mem[0]}, 32'h5A);
        check("wrap_ram1", {24'b0, dut.u_ram.mem[1]}, 32'h5A);
        check("wrap_rdata", rdata, 32'h3344AABB);

        // read and write both set
        access(1'b1, 1'b1, 32'h10, 32'h0, lat);
        check("rw_latency", lat, 32'd1);
        check("rw_err", {31'b0, dmem_error}, 32'd1);
        check("rw_rdata", rdata, 32'h3344AABB);
        access(1'b1, 1'b0, 32'h10, 32'h0, lat);
        check("rw_clear_err", {31'b0, dmem_error}, 32'd0);
        check("rw_reread", rdata, 32'h12345678);

        // start with neither strobe is ignored
        issue(1'b0, 1'b0, 32'h10, 32'h0);
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            @(posedge clk);
            #1;
        end
        check("nop_done", n_done, 32'd0);
        check("nop_busy", n_busy, 32'd0);

        // Second start during an access is dropped
        access(1'b0, 1'b1, 32'h34, 32'h01020304, lat);
        issue(1'b0, 1'b1, 32'h30, 32'h0BADF00D);
        @(negedge clk);
        start = 1'b1;
        write = 1'b1;
        addr  = 32'h34;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        write = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) n_done++;
            @(posedge clk);
            #1;
        end
        check("lock_done_cnt", n_done, 32'd1);
        check("lock_ram30", {24'b0, dut.u_ram.mem[48]}, 32'h0D);
        check("lock_ram33", {24'b0, dut.u_ram.mem[51]}, 32'h0B);
        check("lock_ram34", {24'b0, dut.u_ram.mem[52]}, 32'h04);
        check("lock_ram37", {24'b0, dut.u_ram.mem[55]}, 32'h01);

        // Reset after two bytes of a write
        access(1'b0, 1'b1, 32'h40, 32'h55667788, lat);
        issue(1'b0, 1'b1, 32'h40, 32'hCAFEBABE);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_err", {31'b0, dmem_error}, 32'd0);
        check("mid_rst_state", {30'b0, dut.state_q}, 32'd0);
        check("mid_rst_ram40", {24'b0, dut.u_ram.mem[64]}, 32'hBE);
        check("mid_rst_ram41", {24'b0, dut.u_ram.mem[65]}, 32'hBA);
        check("mid_rst_ram42", {24'b0, dut.u_ram.mem[66]}, 32'h66);
        check("mid_rst_ram43", {24'b0, dut.u_ram.mem[67]}, 32'h55);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("post_rst_no_done", n_done, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Byte-serial data-memory controller that sits directly downstream of the memory-stage helpers. It consumes their address, write-data, read and write strobes and performs the Y86 data-memory access. The result is returned as valM together with dmem_error, which feeds the STAT logic. Words are stored little-endian in a byte-wide RAM and transferred one byte per cycle.

## Interface
Parameters:
- DATA_WID, default `DATA_WID from head.v (32): word width in bits; must be a multiple of 8.
- MEM_BYTES, default 1024: RAM size in bytes.
- BYTES, derived as DATA_WID/8: bytes per word.

Ports:
- clk, input, 1: single clock; all state changes on rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request strobe; sampled only in IDLE.
- read, input, 1: read request (from MEM_READ).
- write, input, 1: write request (from MEM_WRITE).
- addr, input, DATA_WID: byte address of the word (from MEM_ADDR).
- wdata, input, DATA_WID: write data (from MEM_DATA).
- rdata, output, DATA_WID: valM; last completed read result.
- busy, output, 1: access in progress; the pipeline stalls while high.
- done, output, 1: one-cycle completion pulse.
- dmem_error, output, 1: the last request was illegal; held until the next accepted start.

## Operation
- States: IDLE, ACCESS, DONE. On reset, all states go to IDLE and rdata, busy, done and dmem_error are 0. RAM contents are not reset.
- Request acceptance in IDLE:
  - start=1 with exactly one of read/write set: latch addr, wdata, op and clear dmem_error.
  - If the request is legal, go to ACCESS with byte counter cnt=0.
  - If it is illegal, go to DONE with dmem_error=1.
- A request is illegal when read and write are both 1, or when addr+BYTES > MEM_BYTES. The sum is computed at DATA_WID+1 bits, so addresses near the top of the range never wrap.
- start with read=write=0 is ignored: stay in IDLE, no done.
- start outside IDLE is ignored and not queued.
- ACCESS runs one byte per cycle at RAM address addr_q+cnt:
  - Write: store wdata_q[8*cnt +: 8].
  - Read: capture the RAM byte into rbuf[8*cnt +: 8].
  - When cnt==BYTES-1, go to DONE; otherwise increment cnt.
- DONE lasts one cycle with done=1, then returns to IDLE.
  - On entry to DONE after a legal read, rdata takes rbuf.
  - rdata is otherwise held, including across writes and errors.
- An illegal request never touches the RAM and never changes rdata.
- Unaligned addresses are legal.
- Reset mid-access aborts immediately. Bytes already written stay written, and no done is produced.

## Timing
- busy=1 in ACCESS and DONE, and 0 in IDLE.
- Legal access: start accepted at edge T0. busy rises after T0. done is high during cycle T0+BYTES+1. The next start can be accepted at the edge that ends DONE. Latency from start to done is BYTES+1 cycles (5 cycles for 32-bit).
- Illegal access: done and dmem_error are high in the cycle after acceptance (latency 1). busy is high for that one cycle.
- The RAM uses a synchronous write and an asynchronous read. Within ACCESS a read byte is therefore available in the same cycle it is addressed.
- The upstream block must hold addr, wdata, read and write stable only in the start cycle; they are latched.
- dmem_error and rdata are stable from DONE until the next accepted start.

## Structure
- head.v holds DATA_WID and the state encodings IDLE/ACCESS/DONE as `defines. MEM_BYTES stays a module parameter.
- Sub-module dmem_byte_ram: MEM_BYTES×8 RAM with synchronous write and asynchronous read, and no reset.
- dmem_unit holds the FSM, the address/data latches, cnt, rbuf and the range check.

## Test plan
- Write then read (DATA_WID=32):
  - Write 0x12345678 at 0x10, then read 0x10.
  - Required: done at T0+5 for each access. RAM bytes 0x10..0x13 are 78,56,34,12. rdata is 0x12345678. dmem_error stays 0.
- Unaligned read:
  - Write 0xAABBCCDD at 0x20 and 0x11223344 at 0x24, then read 0x22.
  - Required: rdata = 0x3344AABB.
- Range errors:
  - Read at 1021 with MEM_BYTES=1024: done and dmem_error=1 at T0+1, rdata unchanged.
  - Write at 0xFFFFFFFE: dmem_error=1, no wrap to address 0, and RAM[0..1] unchanged.
- Protocol errors and ignored strobes:
  - start with read=write=1: dmem_error=1 after one cycle.
  - start with read=write=0: no done, busy stays 0.
- Busy lockout:
  - Pulse start again 2 cycles into a write.
  - Required: the second start is ignored, exactly one done, and the RAM holds only the first write's data.
- Reset mid-write:
  - Deassert rst_n after 2 bytes of a write of 0xCAFEBABE at 0x40.
  - Required: all outputs are 0 and the FSM is in IDLE. RAM 0x40..0x41 = BE,BA. RAM 0x42..0x43 are unchanged.
